// File: rtl/msj_encoder_pkg.sv
// Shared types and helpers for the msj joint encoder front end.
// Optional index/homing support is enabled with MSJ_ENCODER_INDEX_EN.
package msj_encoder_pkg;

  localparam int unsigned POS_W = 32;
  localparam int unsigned ERR_W = 16;

  typedef logic [1:0] quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_t;

  function automatic step_t decode_step(input quad_state_t prev, input quad_state_t cur);
    logic [1:0] delta;
    step_t      result;
    // Gray order 00,01,11,10 maps to 0..3; the modulo-4 difference is the step.
    delta = {cur[1], cur[1] ^ cur[0]} - {prev[1], prev[1] ^ prev[0]};
    case (delta)
      2'd0:    result = STEP_NONE;
      2'd1:    result = STEP_UP;
      2'd3:    result = STEP_DOWN;
      default: result = STEP_ILLEGAL;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/msj_quad_filter.sv
// Two-flop synchroniser plus stability filter for the A/B encoder pair.
// A new AB value reaches ab_q only after FILTER_LEN stable cycles (0 = bypass).
module msj_quad_filter
  import msj_encoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  output quad_state_t ab_q
);

  quad_state_t sync1;
  quad_state_t sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

  if (FILTER_LEN == 0) begin : g_bypass
    assign ab_q = sync2;
  end else begin : g_filter
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    quad_state_t      cand;
    quad_state_t      ab_r;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] run_next;

    // run_next counts consecutive cycles the synchronised value has been unchanged.
    always_comb begin
      run_next = run_len;
      if (sync2 != cand) begin
        run_next = CNT_W'(1);
      end else if (run_len < CNT_W'(FILTER_LEN)) begin
        run_next = run_len + 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cand    <= '0;
        run_len <= '0;
        ab_r    <= '0;
      end else begin
        cand    <= sync2;
        run_len <= run_next;
        if (run_next == CNT_W'(FILTER_LEN)) begin
          ab_r <= sync2;
        end
      end
    end

    assign ab_q = ab_r;
  end

endmodule

// File: rtl/msj_encoder_frontend.sv
// Quadrature encoder front end: 4x decode, position count, per-period velocity
// and controller update strobe. Define MSJ_ENCODER_INDEX_EN for index homing.
module msj_encoder_frontend
  import msj_encoder_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 50000,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned PULSE_CYCLES  = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enable,
  input  logic                    invert,
  input  logic                    zero_position,
  output logic signed [POS_W-1:0] position,
  output logic signed [POS_W-1:0] velocity,
  output logic                    update_controller,
  output logic [ERR_W-1:0]        illegal_count,
  output logic                    illegal_seen
`ifdef MSJ_ENCODER_INDEX_EN
  ,
  input  logic                    enc_z,
  input  logic                    index_arm,
  output logic                    index_seen
`endif
);

  localparam int unsigned TMR_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned PLS_W = $clog2(PULSE_CYCLES + 1);
  localparam logic signed [POS_W-1:0] ONE = 1;

  typedef enum logic {
    STB_IDLE,
    STB_PULSE
  } stb_state_t;

  quad_state_t             ab_q;
  quad_state_t             ab_prev;
  step_t                   step;
  logic                    home;
  logic                    clear_pos;
  logic                    terminal;
  logic signed [POS_W-1:0] pos_count;
  logic signed [POS_W-1:0] pos_next;
  logic signed [POS_W-1:0] last_sample;
  logic signed [POS_W-1:0] last_next;
  logic [ERR_W-1:0]        illegal_next;
  logic [TMR_W-1:0]        timer;
  logic [TMR_W-1:0]        timer_next;
  stb_state_t              stb_state;
  stb_state_t              stb_next;
  logic [PLS_W-1:0]        pulse_cnt;
  logic [PLS_W-1:0]        pulse_next;

  msj_quad_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clock  (clock),
    .reset_n(reset_n),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .ab_q   (ab_q)
  );

`ifdef MSJ_ENCODER_INDEX_EN
  logic [1:0] z_sync;
  logic       z_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      z_sync     <= '0;
      z_d        <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      z_sync <= {z_sync[0], enc_z};
      z_d    <= z_sync[1];
      if (!index_arm) begin
        index_seen <= 1'b0;
      end else if (home) begin
        index_seen <= 1'b1;
      end
    end
  end

  assign home = z_sync[1] & ~z_d & index_arm;
`else
  assign home = 1'b0;
`endif

  assign step      = decode_step(ab_prev, ab_q);
  assign clear_pos = zero_position | home;
  assign terminal  = enable && (timer == TMR_W'(PERIOD_CYCLES - 1));

  // A clear takes priority over any step decoded in the same cycle.
  always_comb begin
    pos_next     = pos_count;
    illegal_next = illegal_count;
    if (clear_pos) begin
      pos_next = '0;
    end else if (step == STEP_UP) begin
      pos_next = invert ? pos_count - ONE : pos_count + ONE;
    end else if (step == STEP_DOWN) begin
      pos_next = invert ? pos_count + ONE : pos_count - ONE;
    end
    if (step == STEP_ILLEGAL && illegal_count != '1) begin
      illegal_next = illegal_count + 1'b1;
    end
  end

  always_comb begin
    last_next = last_sample;
    if (clear_pos) begin
      last_next = '0;
    end else if (terminal) begin
      last_next = pos_count;
    end
    timer_next = timer + 1'b1;
    if (!enable || terminal) begin
      timer_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ab_prev       <= '0;
      pos_count     <= '0;
      last_sample   <= '0;
      timer         <= '0;
      position      <= '0;
      velocity      <= '0;
      illegal_count <= '0;
      illegal_seen  <= 1'b0;
      pulse_cnt     <= '0;
    end else begin
      ab_prev       <= ab_q;
      pos_count     <= pos_next;
      last_sample   <= last_next;
      timer         <= timer_next;
      illegal_count <= illegal_next;
      pulse_cnt     <= pulse_next;
      if (step == STEP_ILLEGAL) begin
        illegal_seen <= 1'b1;
      end
      if (terminal) begin
        position <= pos_count;
        velocity <= pos_count - last_sample;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stb_state <= STB_IDLE;
    end else begin
      stb_state <= stb_next;
    end
  end

  always_comb begin
    stb_next          = stb_state;
    pulse_next        = pulse_cnt;
    update_controller = 1'b0;
    case (stb_state)
      STB_IDLE: begin
        if (terminal) begin
          stb_next   = STB_PULSE;
          pulse_next = PLS_W'(PULSE_CYCLES - 1);
        end
      end
      STB_PULSE: begin
        update_controller = enable;
        if (pulse_cnt == '0) begin
          stb_next = STB_IDLE;
        end else begin
          pulse_next = pulse_cnt - 1'b1;
        end
      end
      default: stb_next = STB_IDLE;
    endcase
    if (!enable) begin
      stb_next = STB_IDLE;
    end
  end

endmodule

// File: tb/tb_msj_encoder_frontend.sv
// Scoreboard bench for msj_encoder_frontend: a driver issues quadrature
// stimulus per sample period and a monitor checks every update strobe.
module tb_msj_encoder_frontend;

  localparam int unsigned P  = 100;
  localparam int unsigned F  = 4;
  localparam int unsigned PW = 2;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enc_a;
  logic               enc_b;
  logic               enable;
  logic               invert;
  logic               zero_position;
  logic signed [31:0] position;
  logic signed [31:0] velocity;
  logic               update_controller;
  logic [15:0]        illegal_count;
  logic               illegal_seen;
`ifdef MSJ_ENCODER_INDEX_EN
  logic               enc_z;
  logic               index_arm;
  logic               index_seen;
`endif

  msj_encoder_frontend #(
    .PERIOD_CYCLES(P),
    .FILTER_LEN   (F),
    .PULSE_CYCLES (PW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enc_a            (enc_a),
    .enc_b            (enc_b),
    .enable           (enable),
    .invert           (invert),
    .zero_position    (zero_position),
    .position         (position),
    .velocity         (velocity),
    .update_controller(update_controller),
    .illegal_count    (illegal_count),
    .illegal_seen     (illegal_seen)
`ifdef MSJ_ENCODER_INDEX_EN
    ,
    .enc_z            (enc_z),
    .index_arm        (index_arm),
    .index_seen       (index_seen)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic signed [31:0] pos;
    logic signed [31:0] vel;
    int unsigned        at;
    int unsigned        width;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: each rising strobe pops one expected sample.
  initial begin : monitor
    logic        prev;
    logic        have;
    int unsigned width;
    exp_t        cur;
    prev  = 1'b0;
    have  = 1'b0;
    width = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n === 1'b1) begin
        if (update_controller && !prev) begin
          check("strobe_expected", 64'(sb.size() != 0), 1);
          have  = (sb.size() != 0);
          width = 0;
          if (have) begin
            cur = sb.pop_front();
            check("strobe_cycle", cyc, cur.at);
            check("position", position, cur.pos);
            check("velocity", velocity, cur.vel);
          end
        end
        if (update_controller) begin
          width++;
          if (have && width > 1) begin
            check("position_stable", position, cur.pos);
            check("velocity_stable", velocity, cur.vel);
          end
        end
        if (!update_controller && prev && have) begin
          check("strobe_width", width, cur.width);
          have = 1'b0;
        end
        prev = update_controller;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // Behavioural model state
  logic [1:0]         gray [4];
  int unsigned        phase;
  int unsigned        next_sample;
  logic signed [31:0] m_pos;
  logic signed [31:0] m_last;
  logic [15:0]        m_ill;
  logic               m_seen;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_pins();
    {enc_a, enc_b} = gray[phase];
  endtask

  task automatic do_step(input bit up, input bit counted);
    phase = up ? (phase + 1) % 4 : (phase + 3) % 4;
    set_pins();
    if (counted) m_pos = m_pos + ((up ^ invert) ? 1 : -1);
  endtask

  task automatic do_jump();
    phase = (phase + 2) % 4;
    set_pins();
    if (m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
    m_seen = 1'b1;
  endtask

  task automatic run_steps(input int unsigned n, input bit up, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) begin
      do_step(up, 1'b1);
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic finish_period(input int unsigned width);
    while (cyc < next_sample - 1) tick();
    sb.push_back('{pos: m_pos, vel: m_pos - m_last, at: next_sample, width: width});
    m_last = m_pos;
    tick();
    next_sample += P;
  endtask

  initial begin : driver
    logic signed [31:0] held;
    int unsigned        n;
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    phase = 0; m_pos = 0; m_last = 0; m_ill = 0; m_seen = 1'b0;
    reset_n = 1'b0; enable = 1'b0; invert = 1'b0; zero_position = 1'b0;
    enc_a = 1'b0; enc_b = 1'b0;
`ifdef MSJ_ENCODER_INDEX_EN
    enc_z = 1'b0; index_arm = 1'b0;
`endif

    // Reset held with toggling encoder lines
    for (int i = 0; i < 5; i++) begin
      tick();
      enc_a = 1'($urandom_range(0, 1));
      enc_b = 1'($urandom_range(0, 1));
      check("rst_position", position, 0);
      check("rst_velocity", velocity, 0);
      check("rst_update", update_controller, 0);
      check("rst_illegal_count", illegal_count, 0);
      check("rst_illegal_seen", illegal_seen, 0);
    end
    enc_a = 1'b0; enc_b = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("idle_position", position, 0);
    check("idle_illegal_count", illegal_count, 0);

    enable = 1'b1;
    next_sample = cyc + P;

    // Forward, inverted and reverse counting, 10 edges per period
    for (int i = 0; i < 4; i++) begin run_steps(10, 1'b1, 10); finish_period(PW); end
    invert = 1'b1;
    for (int i = 0; i < 2; i++) begin run_steps(10, 1'b1, 10); finish_period(PW); end
    invert = 1'b0;
    for (int i = 0; i < 2; i++) begin run_steps(10, 1'b0, 10); finish_period(PW); end

    // Random direction, count and spacing
    for (int i = 0; i < 4; i++) begin
      invert = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 9);
      for (int unsigned k = 0; k < n; k++) begin
        do_step(1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(5, 9)) tick();
      end
      finish_period(PW);
    end
    invert = 1'b0;

    // Short glitches never reach the counter
    for (int i = 0; i < 3; i++) begin
      enc_a = ~enc_a;
      repeat ($urandom_range(1, 3)) tick();
      set_pins();
      repeat (8) tick();
    end
    finish_period(PW);

    // Single illegal double step
    do_jump();
    repeat (20) tick();
    finish_period(PW);
    check("illegal_count_one", illegal_count, m_ill);
    check("illegal_seen", illegal_seen, m_seen);

    // Saturation of the illegal counter
    force dut.illegal_count = 16'hFFFD;
    tick();
    release dut.illegal_count;
    m_ill = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin do_jump(); repeat (10) tick(); end
    finish_period(PW);
    check("illegal_count_sat", illegal_count, 16'hFFFF);
    check("illegal_seen_sticky", illegal_seen, 1);

    // Wrap from the positive limit
    force dut.pos_count = 32'sh7FFFFFFE;
    force dut.last_sample = 32'sh7FFFFFFE;
    tick();
    release dut.pos_count;
    release dut.last_sample;
    m_pos = 32'sh7FFFFFFE;
    m_last = 32'sh7FFFFFFE;
    run_steps(5, 1'b1, 10);
    finish_period(PW);

    // Zero coinciding with a step on the terminal cycle
    run_steps(3, 1'b1, 10);
    while (cyc < next_sample - 7) tick();
    do_step(1'b1, 1'b0);
    while (cyc < next_sample - 1) tick();
    zero_position = 1'b1;
    finish_period(PW);
    zero_position = 1'b0;
    m_pos = 0;
    m_last = 0;
    run_steps(4, 1'b1, 10);
    finish_period(PW);

    // Enable drop mid-strobe, counting continues while disabled
    run_steps(2, 1'b1, 10);
    finish_period(1);
    enable = 1'b0;
    held = m_last;
    run_steps(3, 1'b1, 10);
    repeat (20) tick();
    check("hold_position", position, held);
    check("hold_no_strobe", update_controller, 0);
    enable = 1'b1;
    next_sample = cyc + P;
    run_steps(2, 1'b1, 10);
    finish_period(PW);

`ifdef MSJ_ENCODER_INDEX_EN
    index_arm = 1'b1;
    run_steps(3, 1'b1, 10);
    repeat (10) tick();
    enc_z = 1'b1;
    repeat (10) tick();
    check("index_seen_set", index_seen, 1);
    m_pos = 0;
    m_last = 0;
    enc_z = 1'b0;
    run_steps(2, 1'b1, 10);
    finish_period(PW);
    index_arm = 1'b0;
    repeat (3) tick();
    check("index_seen_clear", index_seen, 0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
